// File: rtl/mem_responder_pkg.sv
// Shared constants for mem_responder: I/O page offsets, STATUS bit layout and decode selects.
package mem_responder_pkg;

  localparam logic [7:0] IO_TXDATA = 8'h00;
  localparam logic [7:0] IO_STATUS = 8'h01;
  localparam logic [7:0] IO_CNT_LO = 8'h02;
  localparam logic [7:0] IO_CNT_HI = 8'h03;

  localparam int unsigned STATUS_FULL_BIT  = 7;
  localparam int unsigned STATUS_OVF_BIT   = 6;
  localparam int unsigned STATUS_EMPTY_BIT = 5;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_IO   = 2'd2
  } sel_e;

  function automatic logic [7:0] status_byte(input logic full, input logic ovf,
                                             input logic empty, input logic [4:0] count);
    logic [7:0] s;
    s                   = {3'b000, count};
    s[STATUS_FULL_BIT]  = full;
    s[STATUS_OVF_BIT]   = ovf;
    s[STATUS_EMPTY_BIT] = empty;
    return s;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Memory port plus console TX stream between the load/store unit side and mem_responder.
interface mem_responder_if;
  logic [15:0] mem_addr;
  logic        mem_store;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output mem_addr, mem_store, mem_dout, tx_ready,
    input  mem_din, tx_data, tx_valid
  );

  modport slave (
    input  mem_addr, mem_store, mem_dout, tx_ready,
    output mem_din, tx_data, tx_valid
  );
endinterface

// File: rtl/mem_responder_byte_fifo.sv
// Circular byte FIFO with wrap-around pointers; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module mem_responder_byte_fifo #(
  parameter  int unsigned Depth = 8,
  localparam int unsigned PtrW  = $clog2(Depth),
  localparam int unsigned CntW  = $clog2(Depth) + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic [7:0]      data_i,
  input  logic            pop_i,
  output logic [7:0]      head_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o
);

  logic [7:0]      mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & (~full_o | pop_i);
  assign pop_ok  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; entries are only visible through count/pointers.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/mem_responder.sv
// Data-memory responder: byte RAM, console TX FIFO and cycle-counter snapshot on one I/O page.
// Optional build macro MEM_RESPONDER_STORE_FWD_EN makes RAM read-during-write return new data.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned RAM_ADDR_W = 15,
  parameter logic [7:0]  IO_PAGE    = 8'hFF,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  mem_responder_if.slave   mem_bus,
  output logic [15:0]      cycle_count
);

  localparam int unsigned RamDepth = 1 << RAM_ADDR_W;
  localparam int unsigned CntW     = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]            offset;
  sel_e                  sel, sel_q;
  logic [RAM_ADDR_W-1:0] ram_idx;
  logic                  ram_we, tx_push, tx_pop, status_wr, snap_wr, ovf_set;
  logic [7:0]            ram_q [RamDepth];
  logic [7:0]            ram_rd_q;
  logic [7:0]            io_rdata, io_rd_q;
  logic                  ovf_q, ovf_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [15:0]           snap_q, snap_d;
  logic [7:0]            fifo_head;
  logic [CntW-1:0]       fifo_count;
  logic                  fifo_full, fifo_empty;

  assign offset  = mem_bus.mem_addr[7:0];
  assign ram_idx = mem_bus.mem_addr[RAM_ADDR_W-1:0];

  // I/O page takes priority when it overlaps the RAM range.
  always_comb begin
    sel = SEL_NONE;
    if (mem_bus.mem_addr[15:8] == IO_PAGE) begin
      sel = SEL_IO;
    end else if ({16'h0000, mem_bus.mem_addr} < (32'd1 << RAM_ADDR_W)) begin
      sel = SEL_RAM;
    end
  end

  assign ram_we    = mem_bus.mem_store & (sel == SEL_RAM);
  assign tx_push   = mem_bus.mem_store & (sel == SEL_IO) & (offset == IO_TXDATA);
  assign status_wr = mem_bus.mem_store & (sel == SEL_IO) & (offset == IO_STATUS);
  assign snap_wr   = mem_bus.mem_store & (sel == SEL_IO) & (offset == IO_CNT_LO);
  assign tx_pop    = ~fifo_empty & mem_bus.tx_ready;
  assign ovf_set   = tx_push & fifo_full & ~tx_pop;

  mem_responder_byte_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (tx_push),
    .data_i  (mem_bus.mem_dout),
    .pop_i   (tx_pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign mem_bus.tx_data  = fifo_head;
  assign mem_bus.tx_valid = ~fifo_empty;

  // Register reads use pre-edge state so a same-cycle store is not visible yet.
  always_comb begin
    io_rdata = 8'h00;
    case (offset)
      IO_STATUS: io_rdata = status_byte(fifo_full, ovf_q, fifo_empty, 5'(fifo_count));
      IO_CNT_LO: io_rdata = snap_q[7:0];
      IO_CNT_HI: io_rdata = snap_q[15:8];
      default:   io_rdata = 8'h00;
    endcase
  end

  always_comb begin
    ovf_d  = ovf_q;
    cnt_d  = cnt_q + 16'd1;
    snap_d = snap_q;
    if (status_wr) ovf_d = 1'b0;
    if (ovf_set)   ovf_d = 1'b1;
    if (snap_wr)   snap_d = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q   <= SEL_NONE;
      io_rd_q <= 8'h00;
      ovf_q   <= 1'b0;
      cnt_q   <= 16'h0000;
      snap_q  <= 16'h0000;
    end else begin
      sel_q   <= sel;
      io_rd_q <= io_rdata;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= mem_bus.mem_dout;
`ifdef MEM_RESPONDER_STORE_FWD_EN
    ram_rd_q <= ram_we ? mem_bus.mem_dout : ram_q[ram_idx];
`else
    ram_rd_q <= ram_q[ram_idx];
`endif
  end

  always_comb begin
    mem_bus.mem_din = 8'h00;
    unique case (sel_q)
      SEL_RAM: mem_bus.mem_din = ram_rd_q;
      SEL_IO:  mem_bus.mem_din = io_rd_q;
      default: mem_bus.mem_din = 8'h00;
    endcase
  end

  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: read expectations queue up as addresses are driven
// and are popped against mem_din one cycle later; a small TX queue models the FIFO.
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic [15:0] cycle_count;

  mem_responder_if bus ();

  mem_responder dut (
    .clk         (clk),
    .rst         (rst),
    .mem_bus     (bus),
    .cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [7:0] exp_q  [$];
  bit         chk_q  [$];
  string      name_q [$];
  logic [7:0] tx_model [$];

  // One bus cycle: queue the mem_din expectation, clock, update the TX model, then score.
  task automatic cyc(input logic [15:0] a, input logic st, input logic [7:0] d,
                     input bit chk, input logic [7:0] e, input string nm);
    bit         pop, push, c;
    logic [7:0] ev, junk;
    string      n;
    bus.mem_addr  = a;
    bus.mem_store = st;
    bus.mem_dout  = d;
    exp_q.push_back(e);
    chk_q.push_back(chk);
    name_q.push_back(nm);
    pop  = bus.tx_ready && (tx_model.size() != 0);
    push = st && (a == 16'hFF00) && ((tx_model.size() < 8) || pop);
    @(posedge clk);
    #1;
    if (pop) junk = tx_model.pop_front();
    if (push) tx_model.push_back(d);
    if (rst) tx_model.delete();
    c  = chk_q.pop_front();
    ev = exp_q.pop_front();
    n  = name_q.pop_front();
    if (c) begin
      n_checks++;
      if (bus.mem_din !== ev) begin
        n_fail++;
        $display("FAIL %s: mem_din=%h expected %h", n, bus.mem_din, ev);
      end
    end
    bus.mem_store = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(16'h1234, 1'b0, 8'h00, 1'b1, 8'h00, "rst_inflight");
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.tx_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_tx_valid: got %b expected 0", bus.tx_valid);
    end
    n_checks++;
    if (cycle_count !== 16'h0000) begin
      n_fail++; $display("FAIL rst_cycle_count: got %h expected 0000", cycle_count);
    end
    cyc(16'hFF01, 1'b0, 8'h00, 1'b1, 8'h20, "rst_status");
    cyc(16'hFF02, 1'b0, 8'h00, 1'b1, 8'h00, "rst_snap_lo");
  endtask

  task automatic test_ram();
    cyc(16'h1234, 1'b1, 8'hA5, 1'b0, 8'h00, "");
    cyc(16'h7FFF, 1'b1, 8'h5A, 1'b0, 8'h00, "");
    cyc(16'h9000, 1'b1, 8'h77, 1'b0, 8'h00, "");
    cyc(16'h1234, 1'b0, 8'h00, 1'b1, 8'hA5, "ram_read_1234");
    cyc(16'h9000, 1'b0, 8'h00, 1'b1, 8'h00, "unmapped_9000");
    cyc(16'h7FFF, 1'b0, 8'h00, 1'b1, 8'h5A, "ram_read_top");
    cyc(16'h8000, 1'b0, 8'h00, 1'b1, 8'h00, "unmapped_8000");
    cyc(16'hFF10, 1'b0, 8'h00, 1'b1, 8'h00, "io_other_offset");
  endtask

  task automatic test_rdw();
    logic [7:0] e;
`ifdef MEM_RESPONDER_STORE_FWD_EN
    e = 8'h3C;
`else
    e = 8'h11;
`endif
    cyc(16'h0010, 1'b1, 8'h11, 1'b0, 8'h00, "");
    cyc(16'h0010, 1'b1, 8'h3C, 1'b1, e, "rdw_same_addr");
    cyc(16'h0010, 1'b0, 8'h00, 1'b1, 8'h3C, "rdw_after");
  endtask

  task automatic test_fifo_overflow();
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cyc(16'hFF00, 1'b1, 8'(8'h40 + i), 1'b1, 8'h00, "txdata_read");
    end
    cyc(16'hFF01, 1'b0, 8'h00, 1'b1, 8'hC8, "status_full_ovf");
    n_checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h40) begin
      n_fail++;
      $display("FAIL fifo_head: valid=%b data=%h expected 1 40", bus.tx_valid, bus.tx_data);
    end
    cyc(16'hFF01, 1'b1, 8'hFF, 1'b1, 8'hC8, "status_pre_clear");
    cyc(16'hFF01, 1'b0, 8'h00, 1'b1, 8'h88, "status_cleared");
  endtask

  task automatic test_fifo_wrap();
    logic [7:0] want;
    bus.tx_ready = 1'b1;
    cyc(16'hFF00, 1'b1, 8'h50, 1'b0, 8'h00, "");
    bus.tx_ready = 1'b0;
    cyc(16'hFF01, 1'b0, 8'h00, 1'b1, 8'h88, "full_push_pop_status");
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      want = (tx_model.size() != 0) ? tx_model[0] : 8'hXX;
      n_checks++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== want) begin
        n_fail++;
        $display("FAIL drain_%0d: valid=%b data=%h expected 1 %h", i, bus.tx_valid,
                 bus.tx_data, want);
      end
      cyc(16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, "");
    end
    bus.tx_ready = 1'b0;
    n_checks++;
    if (bus.tx_valid !== 1'b0) begin
      n_fail++; $display("FAIL drained_valid: got %b expected 0", bus.tx_valid);
    end
    cyc(16'hFF01, 1'b0, 8'h00, 1'b1, 8'h20, "drained_status");
  endtask

  task automatic test_counter();
    do_reset();
    for (int i = 0; i < 300; i++) cyc(16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, "");
    n_checks++;
    if (cycle_count !== 16'd300) begin
      n_fail++; $display("FAIL cycle_count_300: got %0d expected 300", cycle_count);
    end
    cyc(16'hFF02, 1'b1, 8'h99, 1'b1, 8'h00, "snap_pre_update");
    cyc(16'hFF02, 1'b0, 8'h00, 1'b1, 8'h2C, "cnt_lo");
    cyc(16'hFF03, 1'b1, 8'h55, 1'b1, 8'h01, "cnt_hi");
    cyc(16'hFF03, 1'b0, 8'h00, 1'b1, 8'h01, "cnt_hi_store_ignored");
  endtask

  task automatic test_reset_mid();
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc(16'hFF00, 1'b1, 8'(8'hE0 + i), 1'b0, 8'h00, "");
    cyc(16'hFF01, 1'b0, 8'h00, 1'b1, 8'h03, "status_three");
    n_checks++;
    if (bus.tx_valid !== 1'b1) begin
      n_fail++; $display("FAIL pending_valid: got %b expected 1", bus.tx_valid);
    end
    do_reset();
    n_checks++;
    if (bus.tx_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_valid: got %b expected 0", bus.tx_valid);
    end
    cyc(16'hFF01, 1'b0, 8'h00, 1'b1, 8'h20, "reset_mid_status");
  endtask

  initial begin
    rst           = 1'b1;
    bus.mem_addr  = 16'h0000;
    bus.mem_store = 1'b0;
    bus.mem_dout  = 8'h00;
    bus.tx_ready  = 1'b0;
    test_reset();
    test_ram();
    test_rdw();
    test_fifo_overflow();
    test_fifo_wrap();
    test_counter();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
